ssd1351_spi_sink: RTL and testbench
===================================

# ssd1351_spi_sink

Receive-side model of the SSD1351 OLED SPI link driven by `oled_video`. It oversamples `spi_clk` in the system clock domain and deframes bytes using `spi_dc`. It decodes the column-window, row-window and write-RAM commands, and emits one pixel-write strobe per 16-bit colour word with the panel's auto-incremented coordinates. It sits on the panel side of the link: loop-back into a shadow `bram_buffer` for self-test, or as the scoreboard front end in the display bench.

## Interface
- `c_x_size`, 128: panel columns; coordinates are 7 bits.
- `c_y_size`, 128: panel rows.
- `clk`  in  1: system clock, the same clock that drives `oled_video`.
- `reset`  in  1: synchronous, active-high.
- `spi_csn`  in  1: chip select, active low.
- `spi_clk`  in  1: serial clock; each rising edge samples one bit.
- `spi_mosi`  in  1: serial data, MSB first.
- `spi_dc`  in  1: 0 = command byte, 1 = data byte; sampled together with bit 0.
- `spi_resn`  in  1: panel reset, active low.
- `cmd_valid`  out  1: one-cycle pulse when a command byte completes.
- `cmd_byte`  out  8: the completed command byte; held until the next command.
- `px_we`  out  1: one-cycle pixel write strobe.
- `px_x`  out  7: column of the pixel being written.
- `px_y`  out  7: row of the pixel being written.
- `px_color`  out  16: RGB565 value, `{hi_byte, lo_byte}`.
- `frame_done`  out  1: pulses with the write of the last pixel in the window.
- `err_partial`  out  1: pulses when `spi_csn` rises with 1 to 7 bits received.

## Operation
- Byte receiver:
  - A rising edge is `spi_clk` = 1 while the previous sample was 0, qualified by `spi_csn` = 0.
  - On each rising edge, `mosi` shifts into an 8-bit register and the 3-bit bit counter increments.
  - On the 8th bit, a byte completes and is tagged with `spi_dc` sampled on that same edge.
  - When `spi_csn` goes high, the bit counter clears. If the count was nonzero, `err_partial` pulses.
- `spi_resn` = 0 acts like `reset` on all decoder state: state returns to S_IDLE, windows and pointers return to reset values, the high-byte flag clears, and outputs deassert.
- Decoder states:
  - **S_IDLE**: no command is active; data bytes are dropped.
  - **S_COL**: argument 0 sets `col_start`, argument 1 sets `col_end`, then the state goes to S_IDLE.
  - **S_ROW**: same as S_COL for `row_start` and `row_end`.
  - **S_RAM**: data bytes pair up as hi then lo; the lo byte fires `px_we`.
- Command handling:
  - Any command byte (dc = 0) pulses `cmd_valid`, clears the argument index and the hi/lo flag, and selects the next state:
  - 0x15 selects S_COL.
  - 0x75 selects S_ROW.
  - 0x5C selects S_RAM and loads `px_x` = `col_start`, `px_y` = `row_start`.
  - Any other opcode selects S_IDLE; its arguments are ignored.
- Address arithmetic, all 7-bit:
  - After each write, if `x` == `col_end`, then `x` ← `col_start` and `y` advances; otherwise `x` ← `x` + 1, wrapping 127 → 0.
  - `y` advances the same way against `row_end` / `row_start`.
  - If `x` == `col_end` and `y` == `row_end` on a write, `frame_done` pulses with that `px_we`, and the pointers return to (`col_start`, `row_start`).
  - A window with `end` < `start` is not an error; the pointer wraps through 127 → 0 until it matches `end`.
- Arguments are masked to 7 bits.
- Reset values:
  - `col_start` = 0, `col_end` = `c_x_size`-1, `row_start` = 0, `row_end` = `c_y_size`-1.
  - State is S_IDLE.
  - All outputs are 0.

## Timing
- Latency: the clk cycle in which `spi_clk` is first sampled high for a byte's final bit is cycle t. The byte-complete event happens in cycle t+1, and `px_we`, `cmd_valid` and `frame_done` are asserted, registered, in cycle t+2.
- `px_x`, `px_y` and `px_color` are valid only while `px_we` = 1. The pointer update becomes visible at the next write.
- Minimum supported `spi_clk` high or low time is 1 clk cycle, i.e. SCK ≤ clk/2.
- If `reset` or `spi_resn` is asserted in the same cycle as a completing byte, reset wins and nothing is emitted.
- If `spi_csn` rises on the same cycle that the 8th bit is sampled, the byte still completes and `err_partial` does not fire.
- A command byte arriving between a hi byte and its lo byte discards the hi byte.

## Configuration
- `SSD1351_SINK_SYNC_EN`:
  - Defined: a 2-flop synchroniser is added on each of `spi_csn`, `spi_clk`, `spi_mosi`, `spi_dc` and `spi_resn`, for use when the inputs come from FPGA pins. All latencies grow by 2 cycles, so outputs appear at t+4.
  - Undefined: inputs are sampled directly, which is valid only when `oled_video` shares `clk`.

## Structure
- Package `ssd1351_pkg` holds:
  - opcode constants `CMD_SET_COL` = 8'h15, `CMD_SET_ROW` = 8'h75, `CMD_WRITE_RAM` = 8'h5C;
  - the decoder state encoding;
  - the RGB565 field widths 5/6/5.
- Sub-module `spi_byte_rx` holds the optional synchroniser, edge detect, shift register, bit counter, `err_partial`, and the byte/dc output strobe.
- The top level is the decoder FSM plus the address counters.

## Test plan
- Default window after reset: send 0x5C then bytes F8,00,07,E0 → two `px_we`: (0,0,16'hF800) then (1,0,16'h07E0).
- Window wrap: send 15,02,03 / 75,05,06 / 5C, then 4 pixels → writes at (2,5),(3,5),(2,6),(3,6), and `frame_done` pulses with the 4th write only.
- Partial byte: 5 bits clocked, then `spi_csn` high → `err_partial` pulses once. The next full byte 0x5C decodes correctly with `cmd_valid` = 1.
- Unknown command: A0,55 followed by data 12,34 → `cmd_valid` with `cmd_byte` = A0 and no `px_we`.
- `spi_resn` pulled low mid-stream after a hi byte, then 5C,00,1F → a single write at (0,0,16'h001F).
- Latency check, run with and without `SSD1351_SINK_SYNC_EN`: `px_we` lands exactly 2 (or 4) clk cycles after the final rising edge of `spi_clk` is sampled.

Source files
------------

// File: rtl/ssd1351_pkg.sv
// rtl/ssd1351_pkg.sv - shared opcodes, decoder states and colour widths for the SSD1351 SPI sink
//
// Contents:
//   CMD_SET_COL / CMD_SET_ROW / CMD_WRITE_RAM : decoded opcodes
//   RGB565 field widths and total colour width
//   dec_state_e                               : decoder state encoding
//   coord_step()                              : one window-pointer advance

package ssd1351_pkg;

   localparam logic [7:0] CMD_SET_COL   = 8'h15;
   localparam logic [7:0] CMD_SET_ROW   = 8'h75;
   localparam logic [7:0] CMD_WRITE_RAM = 8'h5C;

   localparam int RGB565_R_W = 5;
   localparam int RGB565_G_W = 6;
   localparam int RGB565_B_W = 5;
   localparam int RGB565_W   = RGB565_R_W + RGB565_G_W + RGB565_B_W;

   localparam int COORD_W = 7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COL  = 2'd1,
      S_ROW  = 2'd2,
      S_RAM  = 2'd3
   } dec_state_e;

   // Reaching the window end reloads the start; otherwise step with natural
   // 7-bit wrap, so windows with end < start run through 127 -> 0.
   function automatic logic [COORD_W-1:0] coord_step(
      input logic [COORD_W-1:0] cur,
      input logic [COORD_W-1:0] first,
      input logic [COORD_W-1:0] last
   );
      if (cur == last) begin
         return first;
      end
      return cur + 7'd1;
   endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - oversampling SPI byte receiver for the SSD1351 sink
//
// Optional build macro: SSD1351_SINK_SYNC_EN adds a 2-flop synchroniser on
// every SPI input (csn, clk, mosi, dc, resn).
//
// Ports:
//   clk, reset              : system clock, synchronous active-high reset
//   spi_csn/clk/mosi/dc     : raw SPI link inputs
//   spi_resn                : raw panel reset (active low)
//   byte_valid              : one-cycle strobe, byte_data/byte_dc valid
//   byte_data, byte_dc      : completed byte and its data/command tag
//   resn_s                  : panel reset aligned with the byte path
//   err_partial             : pulse when csn rises mid-byte

module spi_byte_rx (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_csn,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_dc,
   input  logic       spi_resn,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       resn_s,
   output logic       err_partial
);

   logic csn_s;
   logic sck_s;
   logic mosi_s;
   logic dc_s;

`ifdef SSD1351_SINK_SYNC_EN
   // Ordering {csn, clk, mosi, dc, resn}; idle values keep csn and resn high.
   localparam logic [4:0] SYNC_IDLE = 5'b10001;

   logic [4:0] sync1_q, sync1_d;
   logic [4:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = {spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn};
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= SYNC_IDLE;
         sync2_q <= SYNC_IDLE;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign {csn_s, sck_s, mosi_s, dc_s, resn_s} = sync2_q;
`else
   assign {csn_s, sck_s, mosi_s, dc_s, resn_s} = {spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn};
`endif

   logic       sck_prev_q, sck_prev_d;
   logic       csn_prev_q, csn_prev_d;
   logic [6:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_data_q, byte_data_d;
   logic       byte_dc_q, byte_dc_d;
   logic       err_q, err_d;

   logic       rise;
   logic [2:0] cnt_after;

   always_comb begin
      // An edge is still accepted in the cycle csn rises, so a byte whose
      // last bit coincides with csn deasserting completes normally.
      rise = sck_s & ~sck_prev_q & (~csn_s | ~csn_prev_q);

      sck_prev_d   = sck_s;
      csn_prev_d   = csn_s;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_dc_d    = byte_dc_q;
      cnt_after    = cnt_q;

      if (rise) begin
         shift_d   = {shift_q[5:0], mosi_s};
         cnt_after = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shift_q, mosi_s};
            byte_dc_d    = dc_s;
         end
      end

      err_d = csn_s & ~csn_prev_q & (cnt_after != 3'd0);
      cnt_d = csn_s ? 3'd0 : cnt_after;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_prev_q   <= 1'b0;
         csn_prev_q   <= 1'b1;
         shift_q      <= '0;
         cnt_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_dc_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         sck_prev_q   <= sck_prev_d;
         csn_prev_q   <= csn_prev_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         byte_dc_q    <= byte_dc_d;
         err_q        <= err_d;
      end
   end

   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign byte_dc     = byte_dc_q;
   assign err_partial = err_q;

endmodule

// File: rtl/ssd1351_spi_sink.sv
// rtl/ssd1351_spi_sink.sv - SSD1351 SPI receive-side decoder emitting pixel writes
//
// Optional build macro: SSD1351_SINK_SYNC_EN (input synchroniser in spi_byte_rx,
// adds 2 cycles to every latency).
//
// Ports:
//   clk, reset                : system clock, synchronous active-high reset
//   spi_csn/clk/mosi/dc/resn  : SPI link from oled_video
//   cmd_valid, cmd_byte       : command strobe and last command byte (held)
//   px_we, px_x, px_y         : pixel write strobe and its coordinates
//   px_color                  : RGB565 {hi_byte, lo_byte}
//   frame_done                : with the write of the window's last pixel
//   err_partial               : csn rose with 1..7 bits received

module ssd1351_spi_sink
   import ssd1351_pkg::*;
#(
   parameter int c_x_size = 128,
   parameter int c_y_size = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                spi_csn,
   input  logic                spi_clk,
   input  logic                spi_mosi,
   input  logic                spi_dc,
   input  logic                spi_resn,
   output logic                cmd_valid,
   output logic [7:0]          cmd_byte,
   output logic                px_we,
   output logic [COORD_W-1:0]  px_x,
   output logic [COORD_W-1:0]  px_y,
   output logic [RGB565_W-1:0] px_color,
   output logic                frame_done,
   output logic                err_partial
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(c_x_size - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(c_y_size - 1);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_dc;
   logic       resn_s;

   spi_byte_rx u_rx (
      .clk         (clk),
      .reset       (reset),
      .spi_csn     (spi_csn),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_dc      (spi_dc),
      .spi_resn    (spi_resn),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_dc     (byte_dc),
      .resn_s      (resn_s),
      .err_partial (err_partial)
   );

   dec_state_e          state_q, state_d;
   logic                arg_idx_q, arg_idx_d;
   logic                hi_flag_q, hi_flag_d;
   logic [7:0]          hi_byte_q, hi_byte_d;
   logic [COORD_W-1:0]  col_start_q, col_start_d;
   logic [COORD_W-1:0]  col_end_q, col_end_d;
   logic [COORD_W-1:0]  row_start_q, row_start_d;
   logic [COORD_W-1:0]  row_end_q, row_end_d;
   logic [COORD_W-1:0]  x_q, x_d;
   logic [COORD_W-1:0]  y_q, y_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [7:0]          cmd_byte_q, cmd_byte_d;
   logic                px_we_q, px_we_d;
   logic [COORD_W-1:0]  px_x_q, px_x_d;
   logic [COORD_W-1:0]  px_y_q, px_y_d;
   logic [RGB565_W-1:0] px_color_q, px_color_d;
   logic                frame_done_q, frame_done_d;

   logic [COORD_W-1:0]  arg;

   always_comb begin
      arg = byte_data[COORD_W-1:0];

      state_d      = state_q;
      arg_idx_d    = arg_idx_q;
      hi_flag_d    = hi_flag_q;
      hi_byte_d    = hi_byte_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      row_start_d  = row_start_q;
      row_end_d    = row_end_q;
      x_d          = x_q;
      y_d          = y_q;
      cmd_valid_d  = 1'b0;
      cmd_byte_d   = cmd_byte_q;
      px_we_d      = 1'b0;
      px_x_d       = px_x_q;
      px_y_d       = px_y_q;
      px_color_d   = px_color_q;
      frame_done_d = 1'b0;

      // Panel reset overrides a byte completing in the same cycle.
      if (!resn_s) begin
         state_d     = S_IDLE;
         arg_idx_d   = 1'b0;
         hi_flag_d   = 1'b0;
         hi_byte_d   = '0;
         col_start_d = '0;
         col_end_d   = X_LAST;
         row_start_d = '0;
         row_end_d   = Y_LAST;
         x_d         = '0;
         y_d         = '0;
         cmd_byte_d  = '0;
         px_x_d      = '0;
         px_y_d      = '0;
         px_color_d  = '0;
      end else if (byte_valid) begin
         if (!byte_dc) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_data;
            arg_idx_d   = 1'b0;
            hi_flag_d   = 1'b0;
            case (byte_data)
               CMD_SET_COL:   state_d = S_COL;
               CMD_SET_ROW:   state_d = S_ROW;
               CMD_WRITE_RAM: begin
                  state_d = S_RAM;
                  x_d     = col_start_q;
                  y_d     = row_start_q;
               end
               default:       state_d = S_IDLE;
            endcase
         end else begin
            case (state_q)
               S_COL: begin
                  if (!arg_idx_q) begin
                     col_start_d = arg;
                     arg_idx_d   = 1'b1;
                  end else begin
                     col_end_d = arg;
                     arg_idx_d = 1'b0;
                     state_d   = S_IDLE;
                  end
               end
               S_ROW: begin
                  if (!arg_idx_q) begin
                     row_start_d = arg;
                     arg_idx_d   = 1'b1;
                  end else begin
                     row_end_d = arg;
                     arg_idx_d = 1'b0;
                     state_d   = S_IDLE;
                  end
               end
               S_RAM: begin
                  if (!hi_flag_q) begin
                     hi_byte_d = byte_data;
                     hi_flag_d = 1'b1;
                  end else begin
                     hi_flag_d  = 1'b0;
                     px_we_d    = 1'b1;
                     px_x_d     = x_q;
                     px_y_d     = y_q;
                     px_color_d = {hi_byte_q, byte_data};
                     x_d        = coord_step(x_q, col_start_q, col_end_q);
                     if (x_q == col_end_q) begin
                        y_d          = coord_step(y_q, row_start_q, row_end_q);
                        frame_done_d = (y_q == row_end_q);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         arg_idx_q    <= 1'b0;
         hi_flag_q    <= 1'b0;
         hi_byte_q    <= '0;
         col_start_q  <= '0;
         col_end_q    <= X_LAST;
         row_start_q  <= '0;
         row_end_q    <= Y_LAST;
         x_q          <= '0;
         y_q          <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_byte_q   <= '0;
         px_we_q      <= 1'b0;
         px_x_q       <= '0;
         px_y_q       <= '0;
         px_color_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         arg_idx_q    <= arg_idx_d;
         hi_flag_q    <= hi_flag_d;
         hi_byte_q    <= hi_byte_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         row_start_q  <= row_start_d;
         row_end_q    <= row_end_d;
         x_q          <= x_d;
         y_q          <= y_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_byte_q   <= cmd_byte_d;
         px_we_q      <= px_we_d;
         px_x_q       <= px_x_d;
         px_y_q       <= px_y_d;
         px_color_q   <= px_color_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_byte   = cmd_byte_q;
   assign px_we      = px_we_q;
   assign px_x       = px_x_q;
   assign px_y       = px_y_q;
   assign px_color   = px_color_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd1351_spi_sink.sv
// tb/tb_ssd1351_spi_sink.sv - scoreboard bench for ssd1351_spi_sink

module tb_ssd1351_spi_sink;

`ifdef SSD1351_SINK_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;
   logic        cmd_valid;
   logic [7:0]  cmd_byte;
   logic        px_we;
   logic [6:0]  px_x, px_y;
   logic [15:0] px_color;
   logic        frame_done;
   logic        err_partial;

   ssd1351_spi_sink dut (
      .clk         (clk),
      .reset       (reset),
      .spi_csn     (spi_csn),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_dc      (spi_dc),
      .spi_resn    (spi_resn),
      .cmd_valid   (cmd_valid),
      .cmd_byte    (cmd_byte),
      .px_we       (px_we),
      .px_x        (px_x),
      .px_y        (px_y),
      .px_color    (px_color),
      .frame_done  (frame_done),
      .err_partial (err_partial)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [7:0] b; int cyc; } cmd_exp_t;
   typedef struct { logic [6:0] x; logic [6:0] y; logic [15:0] c; logic fd; int cyc; } px_exp_t;

   cmd_exp_t cmd_q[$];
   px_exp_t  px_q[$];
   int err_exp = 0;
   int err_seen = 0;
   bit mon_en = 0;

   // Reference model: mode 0 none, 1 column args, 2 row args, 3 pixel data.
   int         m_mode, m_arg, m_cs, m_ce, m_rs, m_re, m_n;
   bit         m_hi_v;
   logic [7:0] m_hi;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_mode = 0; m_arg = 0; m_hi_v = 0; m_hi = 8'h00;
      m_cs = 0; m_ce = 127; m_rs = 0; m_re = 127; m_n = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic dc, input int ecyc);
      cmd_exp_t ce;
      px_exp_t  pe;
      int w, h, k;
      if (!dc) begin
         ce.b = b; ce.cyc = ecyc + LAT;
         cmd_q.push_back(ce);
         m_arg = 0; m_hi_v = 0;
         if (b == 8'h15) m_mode = 1;
         else if (b == 8'h75) m_mode = 2;
         else if (b == 8'h5C) begin m_mode = 3; m_n = 0; end
         else m_mode = 0;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (m_arg == 0) begin
            if (m_mode == 1) m_cs = int'(b) % 128; else m_rs = int'(b) % 128;
            m_arg = 1;
         end else begin
            if (m_mode == 1) m_ce = int'(b) % 128; else m_re = int'(b) % 128;
            m_arg = 0; m_mode = 0;
         end
      end else if (m_mode == 3) begin
         if (!m_hi_v) begin
            m_hi = b; m_hi_v = 1;
         end else begin
            w = ((m_ce - m_cs + 128) % 128) + 1;
            h = ((m_re - m_rs + 128) % 128) + 1;
            k = m_n % (w * h);
            pe.x = 7'((m_cs + k % w) % 128);
            pe.y = 7'((m_rs + k / w) % 128);
            pe.c = {m_hi, b};
            pe.fd = (k == w * h - 1);
            pe.cyc = ecyc + LAT;
            px_q.push_back(pe);
            m_n++; m_hi_v = 0;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc, input bit csn_rise_last);
      spi_csn = 1'b0;
      spi_dc = dc;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = b[i];
         spi_clk = 1'b0;
         repeat ($urandom_range(1, 2)) tick();
         spi_clk = 1'b1;
         if (i == 0) begin
            if (csn_rise_last) spi_csn = 1'b1;
            model_byte(b, dc, cyc);
         end
         repeat ($urandom_range(1, 2)) tick();
      end
      spi_clk = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] b);
      send_byte(b, 1'b0, 1'b0);
   endtask

   task automatic dat(input logic [7:0] b);
      send_byte(b, 1'b1, 1'b0);
   endtask

   task automatic end_burst();
      tick();
      spi_csn = 1'b1;
      repeat (3) tick();
   endtask

   task automatic partial_bits(input int n);
      spi_csn = 1'b0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         spi_clk = 1'b0; tick();
         spi_clk = 1'b1; tick();
      end
      spi_clk = 1'b0; tick();
      spi_csn = 1'b1;
      err_exp++;
      repeat (3) tick();
   endtask

   task automatic resn_pulse();
      repeat (6) tick();
      spi_resn = 1'b0;
      repeat (3) tick();
      model_reset();
      spi_resn = 1'b1;
      repeat (4) tick();
   endtask

   // Scoreboard monitor: pops one expectation per DUT output strobe.
   always @(negedge clk) begin
      if (mon_en) begin
         if (err_partial) err_seen++;
         if (frame_done && !px_we) chk("frame_done_without_px_we", 32'd1, 32'd0);
         if (cmd_valid) begin
            if (cmd_q.size() == 0) begin
               chk("cmd_unexpected", {24'd0, cmd_byte}, 32'hFFFF_FFFF);
            end else begin
               cmd_exp_t e;
               e = cmd_q.pop_front();
               chk("cmd_byte", {24'd0, cmd_byte}, {24'd0, e.b});
               chk("cmd_latency", cyc, e.cyc);
            end
         end
         if (px_we) begin
            if (px_q.size() == 0) begin
               chk("px_unexpected", {9'd0, px_x, px_color}, 32'hFFFF_FFFF);
            end else begin
               px_exp_t e;
               e = px_q.pop_front();
               chk("px_x", {25'd0, px_x}, {25'd0, e.x});
               chk("px_y", {25'd0, px_y}, {25'd0, e.y});
               chk("px_color", {16'd0, px_color}, {16'd0, e.c});
               chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
               chk("px_latency", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cs, ce, rs, re, npix;
      reset = 1'b1;
      spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0; spi_resn = 1'b1;
      model_reset();
      repeat (4) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
      chk("rst_px_we", {31'd0, px_we}, 32'd0);
      chk("rst_px_xy", {18'd0, px_x, px_y}, 32'd0);
      chk("rst_px_color", {16'd0, px_color}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_err_partial", {31'd0, err_partial}, 32'd0);
      mon_en = 1;
      tick();

      // Default window after reset.
      cmd(8'h5C); dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);
      end_burst();

      // 2x2 window with wrap and frame_done on the 4th write.
      cmd(8'h15); dat(8'h02); dat(8'h03);
      cmd(8'h75); dat(8'h05); dat(8'h06);
      cmd(8'h5C);
      for (int i = 0; i < 8; i++) dat(8'($urandom));
      end_burst();

      // Partial byte then a clean command.
      partial_bits(5);
      cmd(8'h5C);
      end_burst();

      // Unknown opcode: its arguments and following data are dropped.
      cmd(8'hA0); dat(8'h55); dat(8'h12); dat(8'h34);
      end_burst();

      // Panel reset after a hi byte restores windows and drops the hi byte.
      cmd(8'h15); dat(8'h10); dat(8'h20);
      cmd(8'h5C); dat(8'hAA);
      resn_pulse();
      cmd(8'h5C); dat(8'h00); dat(8'h1F);
      end_burst();

      // Command between hi and lo discards the hi byte.
      cmd(8'h5C); dat(8'h11); cmd(8'h5C); dat(8'h22); dat(8'h33);
      end_burst();

      // csn rising with the 8th bit still completes the byte.
      send_byte(8'h5C, 1'b0, 1'b1); repeat (2) tick();
      send_byte(8'h44, 1'b1, 1'b1); repeat (2) tick();
      send_byte(8'h55, 1'b1, 1'b1); repeat (3) tick();

      // Randomised small windows, unmasked arguments and wrap through 127.
      for (int t = 0; t < 6; t++) begin
         cs = $urandom_range(0, 255); ce = cs + $urandom_range(0, 3);
         rs = $urandom_range(0, 255); re = rs + $urandom_range(0, 2);
         cmd(8'h15); dat(8'(cs)); dat(8'(ce));
         cmd(8'h75); dat(8'(rs)); dat(8'(re));
         cmd(8'h5C);
         npix = $urandom_range(1, 14);
         for (int p = 0; p < npix; p++) begin
            dat(8'($urandom)); dat(8'($urandom));
         end
         if ($urandom_range(0, 1) == 1) cmd(8'($urandom));
         end_burst();
      end

      repeat (20) tick();
      chk("cmd_queue_drained", cmd_q.size(), 32'd0);
      chk("px_queue_drained", px_q.size(), 32'd0);
      chk("err_partial_count", err_seen, err_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
